// File: rtl/reg_file_if.sv
// Register-file access bundle: two combinational read ports, one write port,
// plus the write-back status flags returned to the pipeline control.
interface reg_file_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] RA1;
  logic [ADDR_W-1:0] RA2;
  logic [WIDTH-1:0]  RD1;
  logic [WIDTH-1:0]  RD2;
  logic              WE;
  logic [ADDR_W-1:0] WA;
  logic [WIDTH-1:0]  WD;
  logic              Hazard;
  logic              WB_Valid;

  modport master (
    output RA1, RA2, WE, WA, WD,
    input  RD1, RD2, Hazard, WB_Valid
  );

  modport slave (
    input  RA1, RA2, WE, WA, WD,
    output RD1, RD2, Hazard, WB_Valid
  );
endinterface

// File: rtl/reg_file.sv
// 2R/1W register file with a one-entry write-back stage (r0 hardwired to zero).
// Define REGFILE_BYPASS_EN to forward the pending write to matching reads.
module reg_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic      CLK,
  input  logic      RST_N,
  reg_file_if.slave rf
);

  localparam int NREG = 1 << ADDR_W;

  logic [WIDTH-1:0]  regs_q [NREG];
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_a_q, pend_a_d;
  logic [WIDTH-1:0]  pend_d_q, pend_d_d;

  logic              match1, match2;
  logic [WIDTH-1:0]  arr1, arr2;

  // Writes to r0 never become pending, so r0 is never written.
  always_comb begin
    pend_v_d = rf.WE && (rf.WA != '0);
    pend_a_d = rf.WA;
    pend_d_d = rf.WD;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_v_q <= 1'b0;
      pend_a_q <= '0;
      pend_d_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pend_v_q <= pend_v_d;
      pend_a_q <= pend_a_d;
      pend_d_q <= pend_d_d;
      if (pend_v_q) begin
        regs_q[pend_a_q] <= pend_d_q;
      end
    end
  end

  always_comb begin
    arr1   = (rf.RA1 == '0) ? '0 : regs_q[rf.RA1];
    arr2   = (rf.RA2 == '0) ? '0 : regs_q[rf.RA2];
    match1 = pend_v_q && (rf.RA1 == pend_a_q) && (rf.RA1 != '0);
    match2 = pend_v_q && (rf.RA2 == pend_a_q) && (rf.RA2 != '0);
  end

  // Outputs forced low while reset is held, independent of the array contents.
  always_comb begin
    rf.RD1      = '0;
    rf.RD2      = '0;
    rf.Hazard   = 1'b0;
    rf.WB_Valid = 1'b0;
    if (RST_N) begin
`ifdef REGFILE_BYPASS_EN
      rf.RD1    = match1 ? pend_d_q : arr1;
      rf.RD2    = match2 ? pend_d_q : arr2;
      rf.Hazard = 1'b0;
`else
      rf.RD1    = arr1;
      rf.RD2    = arr2;
      rf.Hazard = match1 || match2;
`endif
      rf.WB_Valid = pend_v_q;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REGFILE_BYPASS_EN.
module tb_reg_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  reg_file_if #(.WIDTH(32), .ADDR_W(5)) rf ();

  reg_file #(.WIDTH(32), .ADDR_W(5)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .rf    (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    rf.WE  = 1'b1;
    rf.WA  = 5'd4;
    rf.WD  = 32'hDEAD_BEEF;
    rf.RA1 = 5'd4;
    rf.RA2 = 5'd0;
    #2;
    n_cmp++; if (rf.RD1 !== 32'h0) begin n_err++; $display("FAIL rst_rd1: got %h want %h", rf.RD1, 32'h0); end
    n_cmp++; if (rf.RD2 !== 32'h0) begin n_err++; $display("FAIL rst_rd2: got %h want %h", rf.RD2, 32'h0); end
    n_cmp++; if (rf.WB_Valid !== 1'b0) begin n_err++; $display("FAIL rst_wbv: got %b want 0", rf.WB_Valid); end
    n_cmp++; if (rf.Hazard !== 1'b0) begin n_err++; $display("FAIL rst_haz: got %b want 0", rf.Hazard); end
    tick();
    n_cmp++; if (rf.WB_Valid !== 1'b0) begin n_err++; $display("FAIL rst_we_ignored: got %b want 0", rf.WB_Valid); end
    rf.WE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++; if (rf.RD1 !== 32'h0) begin n_err++; $display("FAIL rst_no_write_r4: got %h want %h", rf.RD1, 32'h0); end
  endtask

  task automatic test_reset_mid_op();
    rf.WE  = 1'b1;
    rf.WA  = 5'd9;
    rf.WD  = 32'h0000_0055;
    rf.RA1 = 5'd9;
    tick();
    rf.WE = 1'b0;
    n_cmp++; if (rf.WB_Valid !== 1'b1) begin n_err++; $display("FAIL mid_wbv_pre: got %b want 1", rf.WB_Valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rf.WB_Valid !== 1'b0) begin n_err++; $display("FAIL mid_wbv_async: got %b want 0", rf.WB_Valid); end
    n_cmp++; if (rf.RD1 !== 32'h0) begin n_err++; $display("FAIL mid_rd1_async: got %h want %h", rf.RD1, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++; if (rf.RD1 !== 32'h0) begin n_err++; $display("FAIL mid_write_dropped: got %h want %h", rf.RD1, 32'h0); end
  endtask

  task automatic test_write_read();
    rf.WE  = 1'b1;
    rf.WA  = 5'd3;
    rf.WD  = 32'h0000_0010;
    rf.RA2 = 5'd3;
    rf.RA1 = 5'd0;
    tick();
    rf.WE = 1'b0;
    #1;
    n_cmp++; if (rf.WB_Valid !== 1'b1) begin n_err++; $display("FAIL wr_wbv: got %b want 1", rf.WB_Valid); end
    n_cmp++; if (rf.RD2 !== (BYP ? 32'h10 : 32'h0)) begin n_err++; $display("FAIL wr_rd2_pend: got %h want %h", rf.RD2, (BYP ? 32'h10 : 32'h0)); end
    n_cmp++; if (rf.Hazard !== !BYP) begin n_err++; $display("FAIL wr_haz_pend: got %b want %b", rf.Hazard, !BYP); end
    tick();
    n_cmp++; if (rf.RD2 !== 32'h10) begin n_err++; $display("FAIL wr_rd2_commit: got %h want %h", rf.RD2, 32'h10); end
    n_cmp++; if (rf.WB_Valid !== 1'b0) begin n_err++; $display("FAIL wr_wbv_idle: got %b want 0", rf.WB_Valid); end
    n_cmp++; if (rf.Hazard !== 1'b0) begin n_err++; $display("FAIL wr_haz_idle: got %b want 0", rf.Hazard); end
    rf.RA1 = 5'd3;
    #1;
    n_cmp++; if (rf.RD1 !== rf.RD2 || rf.RD1 !== 32'h10) begin n_err++; $display("FAIL same_addr: rd1 %h rd2 %h want %h", rf.RD1, rf.RD2, 32'h10); end
  endtask

  task automatic test_reg0();
    rf.WE  = 1'b1;
    rf.WA  = 5'd0;
    rf.WD  = 32'hFFFF_FFFF;
    rf.RA1 = 5'd0;
    tick();
    rf.WE = 1'b0;
    n_cmp++; if (rf.WB_Valid !== 1'b0) begin n_err++; $display("FAIL r0_wbv: got %b want 0", rf.WB_Valid); end
    n_cmp++; if (rf.Hazard !== 1'b0) begin n_err++; $display("FAIL r0_haz: got %b want 0", rf.Hazard); end
    n_cmp++; if (rf.RD1 !== 32'h0) begin n_err++; $display("FAIL r0_rd1_pend: got %h want %h", rf.RD1, 32'h0); end
    tick();
    n_cmp++; if (rf.RD1 !== 32'h0) begin n_err++; $display("FAIL r0_rd1_after: got %h want %h", rf.RD1, 32'h0); end
  endtask

  task automatic test_back_to_back();
    rf.RA1 = 5'd5;
    rf.WE  = 1'b1;
    rf.WA  = 5'd5;
    rf.WD  = 32'd4;
    tick();
    rf.WD = 32'd16;
    tick();
    rf.WE = 1'b0;
    n_cmp++; if (rf.RD1 !== (BYP ? 32'd16 : 32'd4)) begin n_err++; $display("FAIL b2b_mid: got %h want %h", rf.RD1, (BYP ? 32'd16 : 32'd4)); end
    n_cmp++; if (rf.Hazard !== !BYP) begin n_err++; $display("FAIL b2b_haz: got %b want %b", rf.Hazard, !BYP); end
    tick();
    n_cmp++; if (rf.RD1 !== 32'd16) begin n_err++; $display("FAIL b2b_final: got %h want %h", rf.RD1, 32'd16); end
    tick();
    n_cmp++; if (rf.RD1 !== 32'd16) begin n_err++; $display("FAIL b2b_hold: got %h want %h", rf.RD1, 32'd16); end
  endtask

  task automatic test_hazard();
    rf.RA1 = 5'd7;
    rf.RA2 = 5'd3;
    rf.WE  = 1'b1;
    rf.WA  = 5'd7;
    rf.WD  = 32'h11;
    tick();
    rf.WE = 1'b0;
    tick();
    n_cmp++; if (rf.RD1 !== 32'h11) begin n_err++; $display("FAIL haz_old: got %h want %h", rf.RD1, 32'h11); end
    rf.WE = 1'b1;
    rf.WD = 32'hA5;
    tick();
    rf.WE = 1'b0;
    n_cmp++; if (rf.RD1 !== (BYP ? 32'hA5 : 32'h11)) begin n_err++; $display("FAIL haz_rd1_pend: got %h want %h", rf.RD1, (BYP ? 32'hA5 : 32'h11)); end
    n_cmp++; if (rf.Hazard !== !BYP) begin n_err++; $display("FAIL haz_port1: got %b want %b", rf.Hazard, !BYP); end
    n_cmp++; if (rf.RD2 !== 32'h10) begin n_err++; $display("FAIL haz_rd2_other: got %h want %h", rf.RD2, 32'h10); end
    tick();
    n_cmp++; if (rf.RD1 !== 32'hA5) begin n_err++; $display("FAIL haz_rd1_commit: got %h want %h", rf.RD1, 32'hA5); end
    n_cmp++; if (rf.Hazard !== 1'b0) begin n_err++; $display("FAIL haz_clear: got %b want 0", rf.Hazard); end
    // port 2 alone must raise the hazard
    rf.RA1 = 5'd3;
    rf.RA2 = 5'd12;
    rf.WE  = 1'b1;
    rf.WA  = 5'd12;
    rf.WD  = 32'h1234_5678;
    tick();
    rf.WE = 1'b0;
    n_cmp++; if (rf.Hazard !== !BYP) begin n_err++; $display("FAIL haz_port2: got %b want %b", rf.Hazard, !BYP); end
    n_cmp++; if (rf.RD2 !== (BYP ? 32'h1234_5678 : 32'h0)) begin n_err++; $display("FAIL haz_rd2_pend: got %h want %h", rf.RD2, (BYP ? 32'h1234_5678 : 32'h0)); end
    tick();
    n_cmp++; if (rf.RD2 !== 32'h1234_5678) begin n_err++; $display("FAIL haz_rd2_commit: got %h want %h", rf.RD2, 32'h1234_5678); end
    n_cmp++; if (rf.RD1 !== 32'h10) begin n_err++; $display("FAIL haz_rd1_r3: got %h want %h", rf.RD1, 32'h10); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_reset_mid_op();
    test_write_read();
    test_reg0();
    test_back_to_back();
    test_hazard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data word width.
REQ-002 SHALL have parameter ADDR_W, default 5, the register address width (2^ADDR_W registers).
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port RA1  input  ADDR_W  read address, port 1.
REQ-006 SHALL have port RA2  input  ADDR_W  read address, port 2.
REQ-007 SHALL have port RD1  output  WIDTH  read data, port 1; feeds the ALU operand-A mux.
REQ-008 SHALL have port RD2  output  WIDTH  read data, port 2; feeds the ALU operand-B 2:1 mux (B input).
REQ-009 SHALL have port WE  input  1  write request, sampled at the rising edge of CLK.
REQ-010 SHALL have port WA  input  ADDR_W  write address.
REQ-011 SHALL have port WD  input  WIDTH  write data.
REQ-012 SHALL have port Hazard  output  1  a read address matches an uncommitted pending write.
REQ-013 SHALL have port WB_Valid  output  1  the write-back stage holds a pending write.

Function
REQ-014 SHALL hold 2^ADDR_W registers of WIDTH bits; register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-015 SHALL capture WE, WA and WD into a one-entry write-back stage (pend_v, pend_a, pend_d) at each rising edge; pend_v SHALL be set to WE && (WA != 0).
REQ-016 SHALL commit pend_d to register pend_a at the rising edge following capture when pend_v=1; commit of the old entry and capture of a new entry SHALL occur on the same edge.
REQ-017 SHALL compute RD1/RD2 combinationally from RA1/RA2 with no clock latency.
REQ-018 SHALL have a write latency of 2 edges: data presented at edge N SHALL be in the array after edge N+1.
REQ-019 SHALL resolve back-to-back writes to the same address in issue order, so the later write's data is the final value.
REQ-020 SHALL allow RA1 = RA2, with both ports returning identical data.
REQ-021 SHALL drive WB_Valid = pend_v.
REQ-022 SHALL define a match as pend_v=1 && RAx = pend_a; RAx = 0 SHALL never match.

Reset
REQ-023 SHALL, on RST_N=0, immediately clear every register and pend_v, pend_a and pend_d to 0, independent of CLK.
REQ-024 SHALL drive RD1=0, RD2=0, Hazard=0 and WB_Valid=0 while in reset.
REQ-025 SHALL discard a pending write when reset asserts mid-operation; that write SHALL never reach the array.
REQ-026 SHALL ignore WE at any rising edge where RST_N=0; the first capture SHALL occur at the first rising edge with RST_N=1.

Configuration
REQ-027 SHALL use the macro REGFILE_BYPASS_EN to compile write forwarding in or out.
REQ-028 SHALL, with REGFILE_BYPASS_EN defined, return pend_d on any matching read port and hold Hazard at constant 0.
REQ-029 SHALL, with REGFILE_BYPASS_EN undefined, return the array value on a matching read port (stale data) and drive Hazard=1 whenever either port matches; the upstream control stalls on Hazard.

Verification
REQ-030 Reset with RST_N=0 mid-cycle -> RD1=RD2=0, WB_Valid=0 asynchronously; a write captured one edge earlier SHALL be absent after release.
REQ-031 WE=1, WA=3, WD=0x00000010 at edge N, RA2=3 -> after edge N+1, RD2=0x10; at edge N, WB_Valid=1.
REQ-032 WE=1, WA=0, WD=0xFFFFFFFF, then RA1=0 -> RD1=0 always; WB_Valid stays 0; Hazard stays 0.
REQ-033 Write reg 5 = 4 at edge N, then reg 5 = 16 at edge N+1, RA1=5 -> RD1=16 after edge N+2; value 4 is never the final value.
REQ-034 Bypass on: write reg 7 = 0xA5 and read RA1=7 in the cycle after edge N -> RD1=0xA5 and Hazard=0.
REQ-035 Bypass off: write reg 7 = 0xA5 and read RA1=7 in the cycle after edge N -> RD1 = old value and Hazard=1; after edge N+1, RD1=0xA5 and Hazard=0.
